y_ctrl_seq: RTL

Multi-cycle control sequencer driving the yIF/yID/yEX/yDM/yWB datapath. It owns the program counter and presents it as `PCin` to yIF. It latches each fetched instruction, decodes it, and steps it through FETCH/DECODE/EXEC/MEM/WB with one-cycle write strobes. Each instruction retires with a branch, jump or sequential PC update.

---
 rtl/y_ctrl_pkg.sv | 40 ++++
 rtl/y_ctrl_decode.sv | 56 +++++
 rtl/y_ctrl_seq.sv | 100 ++++++++++
 3 files changed

// File: rtl/y_ctrl_pkg.sv
// Shared constants, state encoding and decode bundle for the y_ctrl sequencer.
package y_ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2a;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  // R-type and addi share the EXEC->WB path, so one class covers both
  typedef enum logic [2:0] {C_ALU, C_LW, C_SW, C_BEQ, C_J} iclass_t;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem2reg;
    logic       reg_write;
    logic [2:0] op;
    iclass_t    cls;
    logic       illegal;
  } dec_t;
endpackage

// File: rtl/y_ctrl_decode.sv
// Combinational IR decode; the sequencer applies all state gating.
module y_ctrl_decode
  import y_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output dec_t        dec
);
  logic unused_ir;
  assign unused_ir = ^ir[25:6];

  always_comb begin
    dec     = '0;
    dec.op  = ALU_ADD;
    dec.cls = C_ALU;
    case (ir[31:26])
      OP_RTYPE: begin
        dec.reg_dst   = 1'b1;
        dec.reg_write = 1'b1;
        case (ir[5:0])
          FN_AND:  dec.op = ALU_AND;
          FN_OR:   dec.op = ALU_OR;
          FN_ADD:  dec.op = ALU_ADD;
          FN_SUB:  dec.op = ALU_SUB;
          FN_SLT:  dec.op = ALU_SLT;
          default: begin
            dec         = '0;
            dec.op      = ALU_ADD;
            dec.illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_LW: begin
        dec.alu_src   = 1'b1;
        dec.mem_read  = 1'b1;
        dec.mem2reg   = 1'b1;
        dec.reg_write = 1'b1;
        dec.cls       = C_LW;
      end
      OP_SW: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec.cls       = C_SW;
      end
      OP_BEQ: begin
        dec.op  = ALU_SUB;
        dec.cls = C_BEQ;
      end
      OP_J:    dec.cls = C_J;
      default: dec.illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/y_ctrl_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer owning the PC and retire count.
module y_ctrl_seq
  import y_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h80,
  parameter int          MAX_INSNS = 43
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] ins,
  input  logic [31:0] PCp4,
  input  logic [31:0] imm,
  input  logic [25:0] jTarget,
  input  logic        zero,
  output logic [31:0] PCin,
  output logic        RegDst,
  output logic        ALUSrc,
  output logic        MemRead,
  output logic        Mem2Reg,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic [2:0]  op,
  output logic        busy,
  output logic        halted,
  output logic        illegal,
  output logic [15:0] icount
);
  state_t      state, state_nxt;
  logic [31:0] ir, pc_nxt;
  logic [15:0] cnt_inc;
  logic        last, active;
  dec_t        dec;

  y_ctrl_decode u_dec (.ir(ir), .dec(dec));

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;

  // last marks the final state of the instruction; the edge leaving it retires
  always_comb begin
    state_nxt = state;
    last      = 1'b0;
    cnt_inc   = (icount == 16'hFFFF) ? icount : icount + 16'd1;
    case (state)
      S_IDLE:   if (start) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: state_nxt = dec.illegal ? S_HALT : S_EXEC;
      S_EXEC: begin
        case (dec.cls)
          C_ALU:       state_nxt = S_WB;
          C_LW, C_SW:  state_nxt = S_MEM;
          default:     last = 1'b1;
        endcase
      end
      S_MEM: begin
        if (dec.cls == C_SW) last = 1'b1;
        else                 state_nxt = S_WB;
      end
      S_WB:    last = 1'b1;
      default: state_nxt = S_HALT;
    endcase
    if (last) state_nxt = (cnt_inc == 16'(MAX_INSNS)) ? S_HALT : S_FETCH;
  end

  always_comb begin
    pc_nxt = PCp4;
    if (dec.cls == C_BEQ && zero) pc_nxt = PCp4 + (imm << 2);
    else if (dec.cls == C_J)      pc_nxt = {4'b0000, jTarget, 2'b00};
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ir      <= '0;
      PCin    <= RESET_PC;
      icount  <= '0;
      illegal <= 1'b0;
    end else begin
      if (state == S_FETCH) ir <= ins;
      if (last) begin
        PCin   <= pc_nxt;
        icount <= cnt_inc;
      end
      if (state == S_DECODE && dec.illegal) illegal <= 1'b1;
    end

  always_comb begin
    active   = state inside {S_DECODE, S_EXEC, S_MEM, S_WB};
    busy     = active || state == S_FETCH;
    halted   = state == S_HALT;
    RegDst   = active && dec.reg_dst;
    ALUSrc   = active && dec.alu_src;
    Mem2Reg  = active && dec.mem2reg;
    op       = active ? dec.op : ALU_ADD;
    MemRead  = state == S_MEM && dec.mem_read;
    MemWrite = state == S_MEM && dec.mem_write;
    RegWrite = state == S_WB && dec.reg_write;
  end
endmodule
